regfile_rn: RTL and testbench
=============================

# regfile_rn

Parametrised architectural register file with rename tags for the out-of-order core, sitting between instruction decode and dispatch. It reads operand data and rename tags for one decoded instruction per cycle and forwards them, with the decoded fields, as a registered dispatch packet. It records rename tags from dispatch, retires committed results from the ROB, and clears all tags on a pipeline flush. Compared with the previous generation, it adds configurable width and depth, hard-wired x0, same-cycle commit and rename forwarding, and a stall-hold on the dispatch packet.

## Interface
- XLEN, 32, register data width
- NREG, 32, number of architectural registers (power of two); NAMEW = log2(NREG)
- TAGW, 4, rename-tag width; tag 0 means "not renamed, data valid"
- OPW / IMMW / ADDRW, 6 / 32 / 32, decoded op, immediate and pc widths
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; low freezes all state and outputs
- clr  in  1  flush (branch mispredict)
- iIND_en  in  1  decoded instruction valid
- iIND_rs1_regnm, iIND_rs2_regnm, iIND_rd_regnm  in  NAMEW  source and destination register names
- iIND_op / iIND_imm / iIND_pc / iIND_pd  in  OPW / IMMW / ADDRW / 1  decoded fields; pd = predicted taken
- iDP_stall  in  1  dispatch cannot accept the packet; hold it
- oDP_en  out  1  packet valid
- oDP_rs1_dt, oDP_rs2_dt  out  XLEN  operand data
- oDP_rs1_nick, oDP_rs2_nick  out  TAGW  operand tags (0 = data valid)
- oDP_rd_regnm / oDP_op / oDP_imm / oDP_pc / oDP_pd  out  as inputs  forwarded fields
- iROB_nick_en, iROB_nick_regnm (NAMEW), iROB_nick (TAGW)  in  rename write from dispatch
- iROB_en, iROB_rd_regnm (NAMEW), iROB_rd_dt (XLEN), iROB_rd_nick (TAGW)  in  commit

## Operation
- State:
  - reg_dt[NREG] and reg_nick[NREG].
  - Entry 0 reads as data 0 and tag 0 at all times.
  - Writes to entry 0 (rename or commit) are ignored.
- Priority per cycle: rst > !rdy (hold everything) > clr > normal.
- Commit (iROB_en):
  - reg_dt[rd] <= iROB_rd_dt unconditionally. Data always retires in program order.
  - reg_nick[rd] <= 0 only if reg_nick[rd] == iROB_rd_nick and no same-cycle rename targets rd.
- Rename (iROB_nick_en, not clr): reg_nick[regnm] <= iROB_nick. Rename wins over a commit tag-clear to the same register.
- clr:
  - All tags <= 0.
  - A commit in the same cycle still writes its data.
  - Rename is ignored.
  - oDP_en <= 0; the held packet is discarded.
- Operand read (combinational lookup, registered output). For each rs, in priority order:
  - rs == 0 → data 0, tag 0.
  - Same-cycle rename to rs → tag = iROB_nick, data = reg_dt[rs]. The renaming instruction is older.
  - Same-cycle commit to rs with reg_nick[rs] == iROB_rd_nick → data = iROB_rd_dt, tag 0.
  - Otherwise → reg_dt[rs], reg_nick[rs].
- Packet register:
  - If iDP_stall && oDP_en: hold all oDP_* unchanged.
  - Else: oDP_en <= iIND_en. If iIND_en, load the operand results and forwarded fields; otherwise zero all oDP_* fields.
- Held-packet tag refresh while stalled:
  - If a commit clears a tag equal to oDP_rsX_nick (nonzero), the held packet takes data = iROB_rd_dt and tag = 0 for that operand.
  - This keeps a stalled packet from waiting on a result that has already retired.
- Decode must not assert iIND_en while the held packet is stalled. If it does, the input is dropped (verification asserts this never happens).

## Timing
- Reset: every reg_dt and reg_nick = 0; every oDP_* output = 0.
- Latency: iIND_en in cycle N → oDP_en and packet valid in cycle N+1.
- Commit or rename in cycle N → visible in array reads from N+1, and forwarded to reads in cycle N.
- clr in cycle N → oDP_en = 0 at N+1; all tags read 0 from N+1.
- rst or clr asserted mid-stall → packet dropped at the next edge.
- rdy low → no array update, outputs held. Inputs presented while rdy is low are ignored.

## Test plan
- Reset then read: rst for 2 cycles, then iIND_en with rs1=5, rs2=0 → next cycle oDP_en=1, data 0, tags 0.
- Rename then commit: rename x5→tag 3; commit x5, tag 3, data 0x1234 → read x5 gives data 0x1234, tag 0. A commit with tag 2 instead → x5 data updated, tag stays 3.
- Same-cycle forwarding:
  - Read x7 while committing x7 (matching tag 4, data 0xBEEF) → packet carries 0xBEEF, tag 0.
  - Read x7 while renaming x7 to tag 6 → packet carries tag 6.
- Rename-vs-commit collision: rename x9→tag 5 and commit x9 with matching old tag 2 in the same cycle → reg_nick[9]=5, reg_dt[9]=committed data.
- x0 and flush:
  - Rename/commit to x0 → reading x0 still gives 0/0.
  - With tags set on x1..x31 and a held packet, assert clr → all tags 0 and oDP_en=0 next cycle.
- Stall hold and refresh: stall a packet with rs1 tag 3; commit tag 3, data 0x55 → held packet shows rs1 data 0x55, tag 0. Deassert stall with iIND_en=0 → oDP_en=0.

Source files
------------

// File: rtl/regfile_rn_if.sv
// Decode, dispatch and ROB-side signals of the renaming register file.
// The slave modport is the register file; the master modport is its environment.
interface regfile_rn_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned TAGW  = 4,
    parameter int unsigned OPW   = 6,
    parameter int unsigned IMMW  = 32,
    parameter int unsigned ADDRW = 32
) ();
    localparam int unsigned NAMEW = $clog2(NREG);

    logic             iIND_en;
    logic [NAMEW-1:0] iIND_rs1_regnm;
    logic [NAMEW-1:0] iIND_rs2_regnm;
    logic [NAMEW-1:0] iIND_rd_regnm;
    logic [OPW-1:0]   iIND_op;
    logic [IMMW-1:0]  iIND_imm;
    logic [ADDRW-1:0] iIND_pc;
    logic             iIND_pd;

    logic             iDP_stall;
    logic             oDP_en;
    logic [XLEN-1:0]  oDP_rs1_dt;
    logic [XLEN-1:0]  oDP_rs2_dt;
    logic [TAGW-1:0]  oDP_rs1_nick;
    logic [TAGW-1:0]  oDP_rs2_nick;
    logic [NAMEW-1:0] oDP_rd_regnm;
    logic [OPW-1:0]   oDP_op;
    logic [IMMW-1:0]  oDP_imm;
    logic [ADDRW-1:0] oDP_pc;
    logic             oDP_pd;

    logic             iROB_nick_en;
    logic [NAMEW-1:0] iROB_nick_regnm;
    logic [TAGW-1:0]  iROB_nick;
    logic             iROB_en;
    logic [NAMEW-1:0] iROB_rd_regnm;
    logic [XLEN-1:0]  iROB_rd_dt;
    logic [TAGW-1:0]  iROB_rd_nick;

    modport master (
        output iIND_en, iIND_rs1_regnm, iIND_rs2_regnm, iIND_rd_regnm,
        output iIND_op, iIND_imm, iIND_pc, iIND_pd, iDP_stall,
        output iROB_nick_en, iROB_nick_regnm, iROB_nick,
        output iROB_en, iROB_rd_regnm, iROB_rd_dt, iROB_rd_nick,
        input  oDP_en, oDP_rs1_dt, oDP_rs2_dt, oDP_rs1_nick, oDP_rs2_nick,
        input  oDP_rd_regnm, oDP_op, oDP_imm, oDP_pc, oDP_pd
    );

    modport slave (
        input  iIND_en, iIND_rs1_regnm, iIND_rs2_regnm, iIND_rd_regnm,
        input  iIND_op, iIND_imm, iIND_pc, iIND_pd, iDP_stall,
        input  iROB_nick_en, iROB_nick_regnm, iROB_nick,
        input  iROB_en, iROB_rd_regnm, iROB_rd_dt, iROB_rd_nick,
        output oDP_en, oDP_rs1_dt, oDP_rs2_dt, oDP_rs1_nick, oDP_rs2_nick,
        output oDP_rd_regnm, oDP_op, oDP_imm, oDP_pc, oDP_pd
    );
endinterface

// File: rtl/regfile_rn.sv
// Architectural register file with rename tags; reads operands for one decoded
// instruction per cycle and presents them as a registered, stall-holdable dispatch packet.
module regfile_rn #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned TAGW  = 4,
    parameter int unsigned OPW   = 6,
    parameter int unsigned IMMW  = 32,
    parameter int unsigned ADDRW = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         clr,
    regfile_rn_if.slave  bus
);
    localparam int unsigned NAMEW = $clog2(NREG);

    typedef struct packed {
        logic             en;
        logic [XLEN-1:0]  rs1_dt;
        logic [XLEN-1:0]  rs2_dt;
        logic [TAGW-1:0]  rs1_nick;
        logic [TAGW-1:0]  rs2_nick;
        logic [NAMEW-1:0] rd_regnm;
        logic [OPW-1:0]   op;
        logic [IMMW-1:0]  imm;
        logic [ADDRW-1:0] pc;
        logic             pd;
    } dp_t;

    logic [XLEN-1:0]  reg_dt_q   [NREG];
    logic [XLEN-1:0]  reg_dt_d   [NREG];
    logic [TAGW-1:0]  reg_nick_q [NREG];
    logic [TAGW-1:0]  reg_nick_d [NREG];
    dp_t              dp_q;
    dp_t              dp_d;

    logic             ren_act;
    logic             commit_wr;
    logic [NAMEW-1:0] rs_nm   [2];
    logic [XLEN-1:0]  op_dt   [2];
    logic [TAGW-1:0]  op_nick [2];

    assign ren_act   = bus.iROB_nick_en && !clr;
    assign commit_wr = bus.iROB_en && (bus.iROB_rd_regnm != '0);
    assign rs_nm[0]  = bus.iIND_rs1_regnm;
    assign rs_nm[1]  = bus.iIND_rs2_regnm;

    // Operand lookup with same-cycle forwarding; a rename beats a commit because
    // the renaming instruction is older than the one being decoded.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            op_dt[i]   = reg_dt_q[rs_nm[i]];
            op_nick[i] = reg_nick_q[rs_nm[i]];
            if (rs_nm[i] == '0) begin
                op_dt[i]   = '0;
                op_nick[i] = '0;
            end else if (ren_act && (bus.iROB_nick_regnm == rs_nm[i])) begin
                op_nick[i] = bus.iROB_nick;
            end else if (bus.iROB_en && (bus.iROB_rd_regnm == rs_nm[i]) &&
                         (reg_nick_q[rs_nm[i]] == bus.iROB_rd_nick)) begin
                op_dt[i]   = bus.iROB_rd_dt;
                op_nick[i] = '0;
            end
        end
    end

    always_comb begin
        reg_dt_d   = reg_dt_q;
        reg_nick_d = reg_nick_q;
        if (rdy) begin
            if (commit_wr) begin
                reg_dt_d[bus.iROB_rd_regnm] = bus.iROB_rd_dt;
            end
            if (clr) begin
                for (int i = 0; i < int'(NREG); i++) begin
                    reg_nick_d[i] = '0;
                end
            end else begin
                if (commit_wr && (reg_nick_q[bus.iROB_rd_regnm] == bus.iROB_rd_nick) &&
                    !(bus.iROB_nick_en && (bus.iROB_nick_regnm == bus.iROB_rd_regnm))) begin
                    reg_nick_d[bus.iROB_rd_regnm] = '0;
                end
                if (bus.iROB_nick_en && (bus.iROB_nick_regnm != '0)) begin
                    reg_nick_d[bus.iROB_nick_regnm] = bus.iROB_nick;
                end
            end
        end
    end

    always_comb begin
        dp_d = dp_q;
        if (rdy) begin
            if (clr) begin
                dp_d = '0;
            end else if (bus.iDP_stall && dp_q.en) begin
                // A held packet picks up results that retire while it waits.
                if (bus.iROB_en && (bus.iROB_rd_nick != '0)) begin
                    if (dp_q.rs1_nick == bus.iROB_rd_nick) begin
                        dp_d.rs1_dt   = bus.iROB_rd_dt;
                        dp_d.rs1_nick = '0;
                    end
                    if (dp_q.rs2_nick == bus.iROB_rd_nick) begin
                        dp_d.rs2_dt   = bus.iROB_rd_dt;
                        dp_d.rs2_nick = '0;
                    end
                end
            end else if (bus.iIND_en) begin
                dp_d.en       = 1'b1;
                dp_d.rs1_dt   = op_dt[0];
                dp_d.rs2_dt   = op_dt[1];
                dp_d.rs1_nick = op_nick[0];
                dp_d.rs2_nick = op_nick[1];
                dp_d.rd_regnm = bus.iIND_rd_regnm;
                dp_d.op       = bus.iIND_op;
                dp_d.imm      = bus.iIND_imm;
                dp_d.pc       = bus.iIND_pc;
                dp_d.pd       = bus.iIND_pd;
            end else begin
                dp_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                reg_dt_q[i]   <= '0;
                reg_nick_q[i] <= '0;
            end
            dp_q <= '0;
        end else begin
            reg_dt_q   <= reg_dt_d;
            reg_nick_q <= reg_nick_d;
            dp_q       <= dp_d;
        end
    end

    assign bus.oDP_en       = dp_q.en;
    assign bus.oDP_rs1_dt   = dp_q.rs1_dt;
    assign bus.oDP_rs2_dt   = dp_q.rs2_dt;
    assign bus.oDP_rs1_nick = dp_q.rs1_nick;
    assign bus.oDP_rs2_nick = dp_q.rs2_nick;
    assign bus.oDP_rd_regnm = dp_q.rd_regnm;
    assign bus.oDP_op       = dp_q.op;
    assign bus.oDP_imm      = dp_q.imm;
    assign bus.oDP_pc       = dp_q.pc;
    assign bus.oDP_pd       = dp_q.pd;
endmodule

// File: tb/tb_regfile_rn.sv
// Self-checking bench for regfile_rn: directed vector table, hand-written corner
// sequences, then random traffic against a behavioural model of the register file.
module tb_regfile_rn;
    localparam int unsigned XLEN = 32, NREG = 32, TAGW = 4, OPW = 6, IMMW = 32, ADDRW = 32;

    logic clk = 1'b0;
    logic rst, rdy, clr;
    always #5 clk = ~clk;

    regfile_rn_if #(.XLEN(XLEN), .NREG(NREG), .TAGW(TAGW), .OPW(OPW), .IMMW(IMMW),
                    .ADDRW(ADDRW)) bus ();

    regfile_rn #(.XLEN(XLEN), .NREG(NREG), .TAGW(TAGW), .OPW(OPW), .IMMW(IMMW),
                 .ADDRW(ADDRW)) dut (.clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic en; logic [31:0] d1; logic [31:0] d2; logic [3:0] t1; logic [3:0] t2;
        logic [4:0] rd; logic [5:0] op; logic [31:0] imm; logic [31:0] pc; logic pd;
    } pkt_t;

    // Reference model: architectural values, tags and the expected packet.
    logic [31:0] m_dt   [32];
    logic [3:0]  m_nick [32];
    pkt_t        m_pkt;

    typedef struct packed {
        logic ind_en; logic [4:0] rs1; logic [4:0] rs2;
        logic ren; logic [4:0] ren_nm; logic [3:0] ren_tag;
        logic com; logic [4:0] com_nm; logic [31:0] com_dt; logic [3:0] com_tag;
        logic [31:0] e_d1; logic [3:0] e_t1; logic [31:0] e_d2; logic [3:0] e_t2;
    } vec_t;
    vec_t vt [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ops(input string name, input logic en, input logic [31:0] d1,
                           input logic [3:0] t1, input logic [31:0] d2, input logic [3:0] t2);
        chk({name, ".en"}, 64'(bus.oDP_en), 64'(en));
        chk({name, ".rs1_dt"}, 64'(bus.oDP_rs1_dt), 64'(d1));
        chk({name, ".rs1_nick"}, 64'(bus.oDP_rs1_nick), 64'(t1));
        chk({name, ".rs2_dt"}, 64'(bus.oDP_rs2_dt), 64'(d2));
        chk({name, ".rs2_nick"}, 64'(bus.oDP_rs2_nick), 64'(t2));
    endtask

    task automatic chk_pkt(input string name);
        chk_ops(name, m_pkt.en, m_pkt.d1, m_pkt.t1, m_pkt.d2, m_pkt.t2);
        chk({name, ".rd"}, 64'(bus.oDP_rd_regnm), 64'(m_pkt.rd));
        chk({name, ".op"}, 64'(bus.oDP_op), 64'(m_pkt.op));
        chk({name, ".imm"}, 64'(bus.oDP_imm), 64'(m_pkt.imm));
        chk({name, ".pc"}, 64'(bus.oDP_pc), 64'(m_pkt.pc));
        chk({name, ".pd"}, 64'(bus.oDP_pd), 64'(m_pkt.pd));
    endtask

    task automatic lookup(input logic [4:0] rs, output logic [31:0] d, output logic [3:0] t);
        d = m_dt[rs];
        t = m_nick[rs];
        if (rs == 5'd0) begin
            d = '0;
            t = '0;
        end else if (bus.iROB_nick_en && !clr && bus.iROB_nick_regnm == rs) begin
            t = bus.iROB_nick;
        end else if (bus.iROB_en && bus.iROB_rd_regnm == rs && m_nick[rs] == bus.iROB_rd_nick) begin
            d = bus.iROB_rd_dt;
            t = '0;
        end
    endtask

    // Applies one clock of the register-file rules to the model from the current inputs.
    task automatic model_step();
        pkt_t nx;
        logic [4:0] rd;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_dt[i] = '0;
                m_nick[i] = '0;
            end
            m_pkt = '0;
            return;
        end
        if (!rdy) return;
        nx = m_pkt;
        if (clr) begin
            nx = '0;
        end else if (bus.iDP_stall && m_pkt.en) begin
            if (bus.iROB_en && bus.iROB_rd_nick != 4'd0 && m_pkt.t1 == bus.iROB_rd_nick) begin
                nx.d1 = bus.iROB_rd_dt;
                nx.t1 = '0;
            end
            if (bus.iROB_en && bus.iROB_rd_nick != 4'd0 && m_pkt.t2 == bus.iROB_rd_nick) begin
                nx.d2 = bus.iROB_rd_dt;
                nx.t2 = '0;
            end
        end else if (bus.iIND_en) begin
            nx.en = 1'b1;
            lookup(bus.iIND_rs1_regnm, nx.d1, nx.t1);
            lookup(bus.iIND_rs2_regnm, nx.d2, nx.t2);
            nx.rd  = bus.iIND_rd_regnm;
            nx.op  = bus.iIND_op;
            nx.imm = bus.iIND_imm;
            nx.pc  = bus.iIND_pc;
            nx.pd  = bus.iIND_pd;
        end else begin
            nx = '0;
        end
        rd = bus.iROB_rd_regnm;
        if (bus.iROB_en && rd != 5'd0) begin
            if (!clr && m_nick[rd] == bus.iROB_rd_nick &&
                !(bus.iROB_nick_en && bus.iROB_nick_regnm == rd))
                m_nick[rd] = '0;
            m_dt[rd] = bus.iROB_rd_dt;
        end
        if (clr) begin
            for (int i = 0; i < 32; i++) m_nick[i] = '0;
        end else if (bus.iROB_nick_en && bus.iROB_nick_regnm != 5'd0) begin
            m_nick[bus.iROB_nick_regnm] = bus.iROB_nick;
        end
        m_pkt = nx;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; clr = 1'b0;
        bus.iIND_en = 1'b0; bus.iIND_rs1_regnm = '0; bus.iIND_rs2_regnm = '0;
        bus.iIND_rd_regnm = '0; bus.iIND_op = '0; bus.iIND_imm = '0; bus.iIND_pc = '0;
        bus.iIND_pd = 1'b0; bus.iDP_stall = 1'b0;
        bus.iROB_nick_en = 1'b0; bus.iROB_nick_regnm = '0; bus.iROB_nick = '0;
        bus.iROB_en = 1'b0; bus.iROB_rd_regnm = '0; bus.iROB_rd_dt = '0; bus.iROB_rd_nick = '0;
    endtask

    task automatic rd_ops(input logic [4:0] rs1, input logic [4:0] rs2);
        bus.iIND_en = 1'b1;
        bus.iIND_rs1_regnm = rs1;
        bus.iIND_rs2_regnm = rs2;
    endtask

    task automatic ren(input logic [4:0] nm, input logic [3:0] tag);
        bus.iROB_nick_en = 1'b1; bus.iROB_nick_regnm = nm; bus.iROB_nick = tag;
    endtask

    task automatic com(input logic [4:0] nm, input logic [31:0] dt, input logic [3:0] tag);
        bus.iROB_en = 1'b1; bus.iROB_rd_regnm = nm; bus.iROB_rd_dt = dt; bus.iROB_rd_nick = tag;
    endtask

    // Decode must never present a new instruction while the packet is held.
    always @(posedge clk) begin
        if (!rst && rdy && !clr && bus.iDP_stall && bus.oDP_en && bus.iIND_en) begin
            n_fail++;
            $display("FAIL ind_during_stall: iIND_en=1 while packet held");
        end
    end

    initial begin
        // ind_en rs1 rs2 | ren nm tag | com nm data tag | exp d1 t1 d2 t2
        vt[0]  = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0,
                   32'h0, 4'd0, 32'h0, 4'd0};
        vt[1]  = '{1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 4'd3, 1'b0, 5'd0, 32'h0, 4'd0,
                   32'h0, 4'd3, 32'h0, 4'd0};
        vt[2]  = '{1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 4'd0, 1'b1, 5'd5, 32'h1234, 4'd3,
                   32'h1234, 4'd0, 32'h1234, 4'd0};
        vt[3]  = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0,
                   32'h1234, 4'd0, 32'h0, 4'd0};
        vt[4]  = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 4'd3, 1'b0, 5'd0, 32'h0, 4'd0,
                   32'h0, 4'd0, 32'h0, 4'd0};
        vt[5]  = '{1'b1, 5'd0, 5'd5, 1'b0, 5'd0, 4'd0, 1'b1, 5'd5, 32'h9999, 4'd2,
                   32'h0, 4'd0, 32'h1234, 4'd3};
        vt[6]  = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0,
                   32'h9999, 4'd3, 32'h0, 4'd0};
        vt[7]  = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd7, 4'd4, 1'b0, 5'd0, 32'h0, 4'd0,
                   32'h0, 4'd0, 32'h0, 4'd0};
        vt[8]  = '{1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 4'd0, 1'b1, 5'd7, 32'hBEEF, 4'd4,
                   32'hBEEF, 4'd0, 32'hBEEF, 4'd0};
        vt[9]  = '{1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 4'd6, 1'b0, 5'd0, 32'h0, 4'd0,
                   32'hBEEF, 4'd6, 32'h0, 4'd0};
        vt[10] = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 4'd2, 1'b0, 5'd0, 32'h0, 4'd0,
                   32'h0, 4'd0, 32'h0, 4'd0};
        vt[11] = '{1'b1, 5'd9, 5'd7, 1'b1, 5'd9, 4'd5, 1'b1, 5'd9, 32'hAAAA, 4'd2,
                   32'h0, 4'd5, 32'hBEEF, 4'd6};
        vt[12] = '{1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0,
                   32'hAAAA, 4'd5, 32'h0, 4'd0};
        vt[13] = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 4'd7, 1'b1, 5'd0, 32'hDEAD, 4'd0,
                   32'h0, 4'd0, 32'h0, 4'd0};
        vt[14] = '{1'b1, 5'd0, 5'd9, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0,
                   32'h0, 4'd0, 32'hAAAA, 4'd5};
        vt[15] = '{1'b0, 5'd9, 5'd9, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0,
                   32'h0, 4'd0, 32'h0, 4'd0};

        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_ops("reset", 1'b0, 32'h0, 4'd0, 32'h0, 4'd0);

        for (int i = 0; i < 16; i++) begin
            idle();
            bus.iIND_en = vt[i].ind_en;
            bus.iIND_rs1_regnm = vt[i].rs1;
            bus.iIND_rs2_regnm = vt[i].rs2;
            bus.iIND_rd_regnm = 5'(i + 1);
            bus.iIND_op = 6'(i + 2);
            bus.iIND_pc = 32'(i * 4);
            if (vt[i].ren) ren(vt[i].ren_nm, vt[i].ren_tag);
            if (vt[i].com) com(vt[i].com_nm, vt[i].com_dt, vt[i].com_tag);
            step();
            chk_ops($sformatf("vec%0d", i), vt[i].ind_en, vt[i].e_d1, vt[i].e_t1,
                    vt[i].e_d2, vt[i].e_t2);
            chk($sformatf("vec%0d.rd", i), 64'(bus.oDP_rd_regnm),
                vt[i].ind_en ? 64'(i + 1) : 64'd0);
            chk($sformatf("vec%0d.pc", i), 64'(bus.oDP_pc), vt[i].ind_en ? 64'(i * 4) : 64'd0);
        end

        // Held packet picks up a result that retires while stalled.
        idle(); ren(5'd3, 4'd3); step();
        idle(); rd_ops(5'd3, 5'd0); step();
        chk_ops("stall.load", 1'b1, 32'h0, 4'd3, 32'h0, 4'd0);
        idle(); bus.iDP_stall = 1'b1; com(5'd3, 32'h55, 4'd3); step();
        chk_ops("stall.refresh", 1'b1, 32'h55, 4'd0, 32'h0, 4'd0);
        idle(); step();
        chk_ops("stall.release", 1'b0, 32'h0, 4'd0, 32'h0, 4'd0);

        // rdy low freezes array and packet.
        idle(); rd_ops(5'd9, 5'd0); step();
        chk_ops("rdy.load", 1'b1, 32'hAAAA, 4'd5, 32'h0, 4'd0);
        idle(); rdy = 1'b0; rd_ops(5'd0, 5'd0); com(5'd9, 32'h77, 4'd5); ren(5'd4, 4'd9);
        step();
        step();
        chk_ops("rdy.hold", 1'b1, 32'hAAAA, 4'd5, 32'h0, 4'd0);
        idle(); rd_ops(5'd9, 5'd4); step();
        chk_ops("rdy.noupd", 1'b1, 32'hAAAA, 4'd5, 32'h0, 4'd0);

        // Flush with tags on every register and a held packet.
        for (int r = 1; r < 32; r++) begin
            idle(); ren(5'(r), 4'((r % 15) + 1)); step();
        end
        idle(); rd_ops(5'd1, 5'd30); step();
        chk_ops("flush.load", 1'b1, 32'h0, 4'd2, 32'h0, 4'd1);
        idle(); bus.iDP_stall = 1'b1; step();
        chk_ops("flush.held", 1'b1, 32'h0, 4'd2, 32'h0, 4'd1);
        idle(); bus.iDP_stall = 1'b1; clr = 1'b1; ren(5'd6, 4'd4); step();
        chk("flush.en", 64'(bus.oDP_en), 64'd0);
        for (int r = 0; r < 32; r += 2) begin
            idle(); rd_ops(5'(r), 5'(r + 1)); step();
            chk($sformatf("flush.t1.x%0d", r), 64'(bus.oDP_rs1_nick), 64'd0);
            chk($sformatf("flush.t2.x%0d", r + 1), 64'(bus.oDP_rs2_nick), 64'd0);
            chk_pkt("flush.read");
        end

        // Reset while a packet is held.
        idle(); rd_ops(5'd9, 5'd0); step();
        idle(); bus.iDP_stall = 1'b1; step();
        chk("rststall.held", 64'(bus.oDP_en), 64'd1);
        idle(); bus.iDP_stall = 1'b1; rst = 1'b1; step();
        chk_ops("rststall.drop", 1'b0, 32'h0, 4'd0, 32'h0, 4'd0);
        idle(); rd_ops(5'd9, 5'd0); step();
        chk_ops("rststall.clean", 1'b1, 32'h0, 4'd0, 32'h0, 4'd0);

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            logic [4:0] rd;
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 24) == 0);
            bus.iDP_stall = ($urandom_range(0, 2) == 0);
            bus.iIND_en = (bus.iDP_stall && m_pkt.en) ? 1'b0 : 1'($urandom_range(0, 1));
            bus.iIND_rs1_regnm = 5'($urandom_range(0, 7));
            bus.iIND_rs2_regnm = 5'($urandom_range(0, 7));
            bus.iIND_rd_regnm = 5'($urandom);
            bus.iIND_op = 6'($urandom);
            bus.iIND_imm = $urandom;
            bus.iIND_pc = $urandom;
            bus.iIND_pd = 1'($urandom);
            if ($urandom_range(0, 2) == 0) ren(5'($urandom_range(0, 7)), 4'($urandom_range(1, 15)));
            if ($urandom_range(0, 1) == 0) begin
                rd = 5'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0, 1: com(rd, $urandom, m_nick[rd]);
                    2: com(rd, $urandom, m_pkt.t1);
                    default: com(rd, $urandom, 4'($urandom));
                endcase
            end
            step();
            chk_pkt($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
